// File: rtl/breakout_game_ctrl_pkg.sv
// Shared types and constants for the breakout game sequencer.
//   state_t       : game state, encodings match Top's newgame..over
//   START_KEY_DEF : keypad code that serves / starts a game
//   BCD_W         : width of one BCD score digit
package breakout_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [4:0]  START_KEY_DEF = 5'h12;
    localparam int unsigned BCD_W         = 4;

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between pong_graph/keypad and the game sequencer.
//   key_code/key_ready : debounced keypad code and ready level
//   hit/miss           : per-frame pulses from pong_graph
//   gra_still          : freeze request back to pong_graph
//   state/score_bcd/balls_left/timer_busy : game status for display
// master = stimulus side, slave = breakout_game_ctrl.
interface breakout_game_ctrl_if;

    logic [4:0]  key_code;
    logic        key_ready;
    logic        hit;
    logic        miss;
    logic        gra_still;
    logic [1:0]  state;
    logic [15:0] score_bcd;
    logic [1:0]  balls_left;
    logic        timer_busy;

    modport master (
        output key_code, key_ready, hit, miss,
        input  gra_still, state, score_bcd, balls_left, timer_busy
    );

    modport slave (
        input  key_code, key_ready, hit, miss,
        output gra_still, state, score_bcd, balls_left, timer_busy
    );

endinterface

// File: rtl/breakout_game_ctrl_bcd_inc4.sv
// Combinational 4-digit BCD increment, saturating at 9999.
//   din  : current 4-digit BCD value, [15:12] = thousands
//   dout : din + 1, or din unchanged when din == 9999
import breakout_pkg::*;

module bcd_inc4 (
    input  logic [15:0] din,
    output logic [15:0] dout
);

    logic carry;

    always_comb begin
        dout  = din;
        carry = 1'b1;
        if (din != 16'h9999) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (carry) begin
                    if (din[i*BCD_W +: BCD_W] == 4'd9) begin
                        dout[i*BCD_W +: BCD_W] = 4'd0;
                    end else begin
                        dout[i*BCD_W +: BCD_W] = din[i*BCD_W +: BCD_W] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Game sequencer downstream of pong_graph.
//   clk, reset : 100 MHz clock, synchronous active-high reset
//   gif        : keypad inputs, hit/miss pulses, and registered outputs
//                gra_still, state, score_bcd, balls_left, timer_busy
// All outputs are registered; gra_still comes from the next state so it is
// 1 exactly when the visible state is not PLAY.
import breakout_pkg::*;

module breakout_game_ctrl #(
    parameter int unsigned BALLS          = 3,
    parameter logic [4:0]  START_KEY      = START_KEY_DEF,
    parameter int unsigned NEWBALL_CYCLES = 200_000_000,
    parameter int unsigned OVER_CYCLES    = 300_000_000,
    parameter int unsigned TW             = 29
) (
    input logic                 clk,
    input logic                 reset,
    breakout_game_ctrl_if.slave gif
);

    localparam logic [TW-1:0] NB_LOAD   = TW'(NEWBALL_CYCLES - 1);
    localparam logic [TW-1:0] OV_LOAD   = TW'(OVER_CYCLES - 1);
    localparam logic [1:0]    BALLS_INI = 2'(BALLS);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   score_q, score_d, score_inc;
    logic [1:0]    balls_q, balls_d;
    logic          key_ready_d;
    logic          gra_still_q;
    logic          timer_busy_q;
    logic          start;

    bcd_inc4 u_inc (
        .din  (score_q),
        .dout (score_inc)
    );

    assign start = gif.key_ready & ~key_ready_d & (gif.key_code == START_KEY);

    always_comb begin
        state_d = state_q;
        timer_d = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        score_d = score_q;
        balls_d = balls_q;
        case (state_q)
            NEWGAME: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = '0;
                    balls_d = 2'(BALLS - 1);
                end
            end
            PLAY: begin
                // hit and miss in one cycle: both the score and the transition apply
                if (gif.hit) score_d = score_inc;
                if (gif.miss) begin
                    if (balls_q == 2'd0) begin
                        state_d = OVER;
                        timer_d = OV_LOAD;
                    end else begin
                        state_d = NEWBALL;
                        balls_d = balls_q - 2'd1;
                        timer_d = NB_LOAD;
                    end
                end
            end
            NEWBALL: begin
                // starts arriving while the pause runs are dropped, not queued
                if (start && timer_q == '0) state_d = PLAY;
            end
            OVER: begin
                if (timer_q == '0) state_d = NEWGAME;
            end
            default: state_d = NEWGAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= NEWGAME;
            timer_q      <= '0;
            score_q      <= '0;
            balls_q      <= BALLS_INI;
            key_ready_d  <= 1'b0;
            gra_still_q  <= 1'b1;
            timer_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            score_q      <= score_d;
            balls_q      <= balls_d;
            key_ready_d  <= gif.key_ready;
            gra_still_q  <= (state_d != PLAY);
            timer_busy_q <= (timer_d != '0);
        end
    end

    assign gif.state      = state_q;
    assign gif.gra_still  = gra_still_q;
    assign gif.score_bcd  = score_q;
    assign gif.balls_left = balls_q;
    assign gif.timer_busy = timer_busy_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed self-checking bench for breakout_game_ctrl with short pauses
// (NEWBALL_CYCLES=8, OVER_CYCLES=12, BALLS=3).
module tb_breakout_game_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cnt;
    int   trans;
    logic [1:0] prev;

    breakout_game_ctrl_if gif();

    breakout_game_ctrl #(
        .BALLS          (3),
        .START_KEY      (5'h12),
        .NEWBALL_CYCLES (8),
        .OVER_CYCLES    (12),
        .TW             (29)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .gif   (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] code);
        gif.key_code  = code;
        gif.key_ready = 1'b1;
        tick();
    endtask

    task automatic release_key;
        gif.key_ready = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        gif.key_code  = 5'h00;
        gif.key_ready = 1'b0;
        gif.hit  = 1'b0;
        gif.miss = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (20) tick();
        chk("rst_state", 32'(gif.state), 32'h0);
        chk("rst_still", 32'(gif.gra_still), 32'h1);
        chk("rst_score", 32'(gif.score_bcd), 32'h0000);
        chk("rst_balls", 32'(gif.balls_left), 32'h3);
        chk("rst_busy", 32'(gif.timer_busy), 32'h0);

        // wrong key in newgame
        press(5'h0C);
        chk("wrongkey_state", 32'(gif.state), 32'h0);
        release_key();

        // first start
        press(5'h12);
        chk("start_state", 32'(gif.state), 32'h1);
        chk("start_still", 32'(gif.gra_still), 32'h0);
        chk("start_balls", 32'(gif.balls_left), 32'h2);
        release_key();

        // 12 hits: exercises the units->tens carry
        for (int i = 0; i < 12; i++) begin
            gif.hit = 1'b1;
            tick();
            gif.hit = 1'b0;
            tick();
        end
        chk("score12", 32'(gif.score_bcd), 32'h0012);

        // run score up to 9998, then saturate
        gif.hit = 1'b1;
        repeat (9986) tick();
        gif.hit = 1'b0;
        tick();
        chk("score9998", 32'(gif.score_bcd), 32'h9998);
        gif.hit = 1'b1;
        tick();
        chk("score9999", 32'(gif.score_bcd), 32'h9999);
        tick();
        tick();
        gif.hit = 1'b0;
        tick();
        chk("score_sat", 32'(gif.score_bcd), 32'h9999);

        // miss with balls remaining -> newball pause
        gif.miss = 1'b1;
        tick();
        gif.miss = 1'b0;
        chk("miss1_state", 32'(gif.state), 32'h2);
        chk("miss1_balls", 32'(gif.balls_left), 32'h1);
        chk("miss1_still", 32'(gif.gra_still), 32'h1);
        cnt = gif.timer_busy ? 1 : 0;
        tick();
        if (gif.timer_busy) cnt++;
        press(5'h12);
        if (gif.timer_busy) cnt++;
        chk("busy_start_ignored", 32'(gif.state), 32'h2);
        gif.key_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gif.timer_busy) cnt++;
            else break;
        end
        chk("busy_cycles", 32'(cnt), 32'd7);
        chk("nb_wait_state", 32'(gif.state), 32'h2);
        press(5'h12);
        chk("nb_start_state", 32'(gif.state), 32'h1);
        release_key();

        // second miss, serve again, third miss -> over
        gif.miss = 1'b1;
        tick();
        gif.miss = 1'b0;
        chk("miss2_balls", 32'(gif.balls_left), 32'h0);
        repeat (10) tick();
        press(5'h12);
        chk("serve3_state", 32'(gif.state), 32'h1);
        release_key();
        gif.miss = 1'b1;
        tick();
        gif.miss = 1'b0;
        chk("over_state", 32'(gif.state), 32'h3);
        chk("over_busy", 32'(gif.timer_busy), 32'h1);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gif.state == 2'b11) cnt++;
            else break;
        end
        chk("over_cycles", 32'(cnt), 32'd12);
        chk("over_to_newgame", 32'(gif.state), 32'h0);
        chk("score_retained", 32'(gif.score_bcd), 32'h9999);

        // hit outside play is ignored
        gif.hit = 1'b1;
        tick();
        gif.hit = 1'b0;
        tick();
        chk("hit_newgame", 32'(gif.score_bcd), 32'h9999);

        // new game clears score
        press(5'h12);
        chk("ng2_state", 32'(gif.state), 32'h1);
        chk("ng2_score", 32'(gif.score_bcd), 32'h0000);
        chk("ng2_balls", 32'(gif.balls_left), 32'h2);
        release_key();

        // simultaneous hit and miss
        gif.hit  = 1'b1;
        gif.miss = 1'b1;
        tick();
        gif.hit  = 1'b0;
        gif.miss = 1'b0;
        chk("hm_score", 32'(gif.score_bcd), 32'h0001);
        chk("hm_state", 32'(gif.state), 32'h2);
        chk("hm_balls", 32'(gif.balls_left), 32'h1);

        // reset mid-newball, timer at 5
        tick();
        tick();
        chk("pre_reset_state", 32'(gif.state), 32'h2);
        chk("pre_reset_busy", 32'(gif.timer_busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_state", 32'(gif.state), 32'h0);
        chk("mid_rst_still", 32'(gif.gra_still), 32'h1);
        chk("mid_rst_score", 32'(gif.score_bcd), 32'h0000);
        chk("mid_rst_balls", 32'(gif.balls_left), 32'h3);
        chk("mid_rst_busy", 32'(gif.timer_busy), 32'h0);
        tick();

        // held start key: exactly one transition
        gif.key_code  = 5'h12;
        gif.key_ready = 1'b1;
        trans = 0;
        prev  = gif.state;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (gif.state != prev) trans++;
            prev = gif.state;
        end
        gif.key_ready = 1'b0;
        chk("held_trans", 32'(trans), 32'd1);
        chk("held_state", 32'(gif.state), 32'h1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/breakout_game_ctrl.md
Name: breakout_game_ctrl

Overview:
- Game-sequencing stage directly downstream of pong_graph.
- Consumes its per-frame hit/miss pulses and the debounced keypad strobe.
- Produces gra_still back to pong_graph, plus the game state, a 4-digit BCD score and the balls remaining.
- Replaces the idle state_reg/state_next stub in Top; score_bcd feeds Seg7Device via segTestData.

Parameters:
- BALLS, 3, balls per game (1..3); width of balls_left is 2.
- START_KEY, 5'h12, keyCode that serves/starts.
- NEWBALL_CYCLES, 200_000_000, clk cycles of enforced pause after a miss (2 s at 100 MHz).
- OVER_CYCLES, 300_000_000, clk cycles spent in over before returning to newgame.
- TW, 29, timer width; must hold max(NEWBALL_CYCLES, OVER_CYCLES).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- key_code  in  5  keypad code, valid while key_ready=1.
- key_ready  in  1  keypad ready level; a press is its 0->1 edge.
- hit  in  1  one-cycle pulse from pong_graph: ball hit paddle.
- miss  in  1  one-cycle pulse from pong_graph: ball passed paddle.
- gra_still  out  1  1 = freeze ball/paddle in pong_graph.
- state  out  2  00 newgame, 01 play, 10 newball, 11 over.
- score_bcd  out  16  four BCD digits, [15:12] = thousands.
- balls_left  out  2  balls still to serve.
- timer_busy  out  1  1 while the pause timer is nonzero.

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high; it is sampled on posedge clk only.
- Reset values: state=newgame, gra_still=1, score_bcd=16'h0000, balls_left=BALLS, timer=0, timer_busy=0, key_ready_d=0.
- All outputs are registered. gra_still is registered from the next-state value, so gra_still=1 exactly when state!=play in the same cycle.
- start = key_ready & ~key_ready_d & (key_code==START_KEY). It is one cycle wide. A held key gives a single start. Other codes are ignored.
- newgame: on start -> play, score_bcd<=0, balls_left<=BALLS-1.
- play:
  - hit -> score +1 (BCD carry per digit; saturates at 9999, no wrap).
  - miss with balls_left==0 -> over, timer<=OVER_CYCLES-1.
  - miss with balls_left!=0 -> newball, balls_left<=balls_left-1, timer<=NEWBALL_CYCLES-1.
- newball: the timer decrements each cycle. A start while timer!=0 is discarded; it is not queued. On start with timer==0 -> play.
- over: the timer decrements. When timer==0 -> newgame. score_bcd is held, for display, until the next game starts.
- hit and miss in the same cycle in play: the score increments and the miss transition is also taken.
- hit/miss outside play are ignored, with no score change.
- The timer saturates at 0 and never underflows. timer_busy = (timer!=0).
- Latency: an input event becomes visible on the outputs 1 cycle after the event edge.
- reset asserted mid-game (any state, timer running) returns every register to its reset value on the next edge.

Decomposition:
- breakout_pkg holds:
  - State localparams NEWGAME/PLAY/NEWBALL/OVER, with encodings identical to Top's newgame..over.
  - START_KEY default.
  - The BCD digit width.
- One natural sub-module: bcd_inc4, combinational 4-digit BCD +1 with saturation at 9999. It is reused by the text/score overlay later.
- The FSM, timer and edge detector stay in breakout_game_ctrl.

Test Plan (NEWBALL_CYCLES=8, OVER_CYCLES=12, BALLS=3):
- Reset then idle 20 cycles -> state=00, gra_still=1, score=0000, balls_left=3. Start press (key_code=12h, key_ready 0->1) -> state=01, gra_still=0, balls_left=2, next cycle.
- In play, 12 hit pulses -> score_bcd=16'h0012. Preload 9998 via 9998 hits (or force), then 3 hits -> 9999 held.
- Miss in play -> state=10, balls_left=1, timer_busy=1 for 7 cycles. A start during the busy window -> still 10. Start after timer_busy=0 -> state=01.
- Third miss with balls_left=0 -> state=11. After 12 cycles -> state=00, score retained. Next start -> score=0000, balls_left=2.
- Same-cycle hit+miss in play with balls_left=2 -> score+1, state=10, balls_left=1. hit in newgame -> score unchanged.
- key_ready held high 50 cycles with key_code=12h -> exactly one transition. key_code=0Ch press -> no transition. reset asserted in newball with timer=5 -> all reset values next edge.
